// File: rtl/frame_source.sv
`timescale 1ns/1ps
// frame_source: streams 4-bit gray pixels from a byte-packed frame buffer
// (2 pixels/byte, low nibble first) into a VGA reader through a 2-byte FIFO.
// Ports: clk, rst_n (async low); next_pixel_in / frame_reset_in strobes
// (asynchronous, synchronized here); pixel_out / pixel_valid / underrun to
// the reader; mem_req / mem_addr / mem_ack / mem_rdata byte read port.
module frame_source #(
   parameter int H_PIXELS = 160,
   parameter int V_PIXELS = 120,
   parameter int ADDR_W   = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              next_pixel_in,
   input  logic              frame_reset_in,
   output logic [3:0]        pixel_out,
   output logic              pixel_valid,
   output logic              underrun,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata
);
   localparam int NBYTES = H_PIXELS * V_PIXELS / 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBYTES - 1);

   logic [2:0]        np_sync_q, np_sync_d;
   logic [2:0]        fr_sync_q, fr_sync_d;
   logic [1:0]        warm_q, warm_d;
   logic              adv_q, adv_d;
   logic              rst_ev_q, rst_ev_d;
   logic [7:0]        fifo_q [2];
   logic [7:0]        fifo_d [2];
   logic              head_q, head_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              phase_q, phase_d;
   logic              under_q, under_d;
   logic              req_q, req_d;
   logic              stale_q, stale_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;

   logic ack, restart, advance, has_data, pop, push, wr_slot;
   logic [7:0] head_byte;

   always_comb begin
      // Shift chain: [0],[1] synchronize, [2] holds the previous sample.
      np_sync_d = {np_sync_q[1:0], next_pixel_in};
      fr_sync_d = {fr_sync_q[1:0], frame_reset_in};
      // Edge detection is held off until the chain has refilled after reset,
      // so a strobe already high at release is not seen as a new edge.
      warm_d    = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      adv_d     = (warm_q == 2'd3) & np_sync_q[1] & ~np_sync_q[2];
      rst_ev_d  = (warm_q == 2'd3) & fr_sync_q[1] & ~fr_sync_q[2];

      ack      = req_q & mem_ack;
      restart  = rst_ev_q;
      advance  = adv_q & ~restart;
      has_data = (cnt_q != 2'd0);
      pop      = advance & has_data & phase_q;
      push     = ack & ~stale_q & ~restart;
      wr_slot  = head_q ^ cnt_q[0];

      fifo_d = fifo_q;
      if (push) fifo_d[wr_slot] = mem_rdata;
      head_d  = head_q ^ pop;
      cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
      phase_d = (advance & has_data) ? ~phase_q : phase_q;
      under_d = under_q | (advance & ~has_data);
      addr_d  = addr_q;
      if (push) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      stale_d = ack ? 1'b0 : stale_q;

      if (restart) begin
         cnt_d   = 2'd0;
         phase_d = 1'b0;
         under_d = 1'b0;
         addr_d  = '0;
         // An in-flight read must still complete; its data is dropped.
         stale_d = req_q & ~ack;
      end

      req_d      = req_q;
      req_addr_d = req_addr_q;
      if (!(req_q && !ack)) begin
         req_d      = (cnt_d != 2'd2);
         req_addr_d = req_d ? addr_d : req_addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         np_sync_q  <= '0;
         fr_sync_q  <= '0;
         warm_q     <= '0;
         adv_q      <= 1'b0;
         rst_ev_q   <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         head_q     <= 1'b0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         under_q    <= 1'b0;
         req_q      <= 1'b0;
         stale_q    <= 1'b0;
         addr_q     <= '0;
         req_addr_q <= '0;
      end else begin
         np_sync_q  <= np_sync_d;
         fr_sync_q  <= fr_sync_d;
         warm_q     <= warm_d;
         adv_q      <= adv_d;
         rst_ev_q   <= rst_ev_d;
         fifo_q     <= fifo_d;
         head_q     <= head_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         under_q    <= under_d;
         req_q      <= req_d;
         stale_q    <= stale_d;
         addr_q     <= addr_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign head_byte   = fifo_q[head_q];
   assign pixel_out   = has_data ? (phase_q ? head_byte[7:4] : head_byte[3:0])
                                 : 4'h0;
   assign pixel_valid = has_data;
   assign underrun    = under_q;
   assign mem_req     = req_q;
   assign mem_addr    = req_addr_q;

endmodule
